// File: rtl/eprisc_bus_pkg.sv
// Shared constants, state encoding and byte-lane helper for the epRISC bus responder.
package eprisc_bus_pkg;

  localparam logic [1:0] SEL_IDLE         = 2'b00;
  localparam int         CMD_RW_BIT       = 7;
  localparam int         CMD_ADDR_MSB     = 6;
  localparam logic [6:0] IRQ_ADDR_DEFAULT = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } busState_t;

  // Byte 0 is the most significant byte, matching the on-wire word order.
  function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/eprisc_bus_sync.sv
// Two-flop synchroniser for the bus clock and a data vector, with rise/fall
// detection on the synchronised bus clock; 2 iClk latency, no backpressure.
module eprisc_bus_sync #(
  parameter int pWidth = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iBusClock,
  input  logic [pWidth-1:0] iData,
  output logic [pWidth-1:0] oData,
  output logic              oRise,
  output logic              oFall
);

  logic [pWidth-1:0] dataMeta;
  logic              clkMeta;
  logic              clkSync;
  logic              clkPrev;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      dataMeta <= '0;
      oData    <= '0;
      clkMeta  <= 1'b0;
      clkSync  <= 1'b0;
      clkPrev  <= 1'b0;
    end else begin
      dataMeta <= iData;
      oData    <= dataMeta;
      clkMeta  <= iBusClock;
      clkSync  <= clkMeta;
      clkPrev  <= clkSync;
    end
  end

  assign oRise = clkSync & ~clkPrev;
  assign oFall = ~clkSync & clkPrev;

endmodule

// File: rtl/eprisc_bus_responder.sv
// epRISC bus responder: decodes command/data frames into local 32-bit register
// accesses; strobes follow the deciding bus edge by ~3 iClk, no local backpressure.
module eprisc_bus_responder
  import eprisc_bus_pkg::*;
#(
  parameter logic [1:0] pDeviceId = 2'd1,
  parameter logic [6:0] pIrqAddr  = IRQ_ADDR_DEFAULT
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [7:0]  iBusMOSI,
  output logic [7:0]  oBusMISO,
  output logic        oBusMISOEnable,
  output logic        oBusInterrupt,
  output logic [6:0]  oRegAddr,
  output logic [31:0] oRegWData,
  output logic        oRegWrite,
  output logic        oRegRead,
  input  logic [31:0] iRegRData,
  input  logic        iIrqPulse
);

  logic [9:0]  syncData;
  logic [1:0]  selSync;
  logic [7:0]  mosiSync;
  logic        busRise;
  logic        busFall;

  eprisc_bus_sync #(.pWidth(10)) uSync (
    .iClk      (iClk),
    .iRst      (iRst),
    .iBusClock (iBusClock),
    .iData     ({iBusSelect, iBusMOSI}),
    .oData     (syncData),
    .oRise     (busRise),
    .oFall     (busFall)
  );

  assign selSync  = syncData[9:8];
  assign mosiSync = syncData[7:0];

  busState_t   state;
  logic        isWrite;
  logic [1:0]  byteCnt;
  logic        wrInc;
  logic [1:0]  rdPipe;
  logic        rdIrq;
  logic [31:0] rdWord;
  logic        pending;

  logic        selected;
  logic        cmdRise;
  logic        wordRise;
  logic        rdStart;
  logic        irqClr;
  logic [6:0]  nextAddr;
  logic [6:0]  rdAddr;
  logic [31:0] shiftWord;

  assign selected  = (selSync == pDeviceId) && (selSync != SEL_IDLE);
  assign cmdRise   = selected && (state == CMD) && busRise;
  assign wordRise  = selected && (state == DATA) && busRise && (byteCnt == 2'd3);
  assign nextAddr  = oRegAddr + 7'd1;
  assign shiftWord = {oRegWData[23:0], mosiSync};
  // Reads start at the command byte and re-arm at every word boundary (prefetch).
  assign rdStart   = (cmdRise && !mosiSync[CMD_RW_BIT]) || (wordRise && !isWrite);
  assign rdAddr    = (state == CMD) ? mosiSync[CMD_ADDR_MSB:0] : nextAddr;
  assign irqClr    = wordRise && isWrite && (oRegAddr == pIrqAddr) && shiftWord[31];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state          <= IDLE;
      isWrite        <= 1'b0;
      byteCnt        <= 2'd0;
      wrInc          <= 1'b0;
      rdPipe         <= 2'b00;
      rdIrq          <= 1'b0;
      rdWord         <= 32'd0;
      pending        <= 1'b0;
      oBusMISO       <= 8'h00;
      oBusMISOEnable <= 1'b0;
      oBusInterrupt  <= 1'b0;
      oRegAddr       <= 7'd0;
      oRegWData      <= 32'd0;
      oRegWrite      <= 1'b0;
      oRegRead       <= 1'b0;
    end else begin
      oBusMISOEnable <= selected;
      oBusInterrupt  <= pending;
      pending        <= iIrqPulse | (pending & ~irqClr);
      oRegWrite      <= 1'b0;
      oRegRead       <= 1'b0;
      wrInc          <= 1'b0;
      rdPipe         <= {rdPipe[0], rdStart};

      if (rdPipe[1])
        rdWord <= rdIrq ? {pending, 31'd0} : iRegRData;

      if (wrInc)
        oRegAddr <= nextAddr;

      // The status register is answered locally and never reaches the register port.
      if (rdStart) begin
        oRegAddr <= rdAddr;
        oRegRead <= (rdAddr != pIrqAddr);
        rdIrq    <= (rdAddr == pIrqAddr);
      end

      if (selected && busFall) begin
        if (state == DATA)
          oBusMISO <= isWrite ? 8'h00 : wordByte(rdWord, byteCnt);
        else
          oBusMISO <= {pending, 6'd0, 1'b1};
      end

      if (!selected) begin
        state   <= IDLE;
        byteCnt <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            byteCnt <= 2'd0;
          end
          CMD: begin
            if (busRise) begin
              isWrite  <= mosiSync[CMD_RW_BIT];
              oRegAddr <= mosiSync[CMD_ADDR_MSB:0];
              state    <= DATA;
            end
          end
          DATA: begin
            if (busRise) begin
              byteCnt <= byteCnt + 2'd1;
              if (isWrite) begin
                oRegWData <= shiftWord;
                if (byteCnt == 2'd3) begin
                  oRegWrite <= (oRegAddr != pIrqAddr);
                  wrInc     <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eprisc_bus_responder.sv
// Directed plus randomized frames against a frame-level register model of the responder.
module tb_eprisc_bus_responder;

  logic        iClk;
  logic        iRst;
  logic        iBusClock;
  logic [1:0]  iBusSelect;
  logic [7:0]  iBusMOSI;
  logic [7:0]  oBusMISO;
  logic        oBusMISOEnable;
  logic        oBusInterrupt;
  logic [6:0]  oRegAddr;
  logic [31:0] oRegWData;
  logic        oRegWrite;
  logic        oRegRead;
  logic [31:0] iRegRData;
  logic        iIrqPulse;

  eprisc_bus_responder #(.pDeviceId(2'd1), .pIrqAddr(7'h7F)) dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .iBusClock      (iBusClock),
    .iBusSelect     (iBusSelect),
    .iBusMOSI       (iBusMOSI),
    .oBusMISO       (oBusMISO),
    .oBusMISOEnable (oBusMISOEnable),
    .oBusInterrupt  (oBusInterrupt),
    .oRegAddr       (oRegAddr),
    .oRegWData      (oRegWData),
    .oRegWrite      (oRegWrite),
    .oRegRead       (oRegRead),
    .iRegRData      (iRegRData),
    .iIrqPulse      (iIrqPulse)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int testCnt = 0;
  int failCnt = 0;
  int bothCnt = 0;
  int longCnt = 0;
  int intLowCnt = 0;
  int enHighCnt = 0;
  logic prevWr = 1'b0;
  logic prevRd = 1'b0;

  logic [31:0] devMem [128];
  logic [31:0] refMem [128];
  logic        refPending;
  logic [38:0] wrQ [$];
  logic [6:0]  rdQ [$];
  logic [31:0] wordsQ [$];

  // Peripheral register file: read data appears one iClk after the read strobe.
  always @(posedge iClk) begin
    if (oRegRead) iRegRData <= devMem[oRegAddr];
    if (oRegWrite) devMem[oRegAddr] = oRegWData;
  end

  always @(negedge iClk) begin
    if (oRegWrite) wrQ.push_back({oRegAddr, oRegWData});
    if (oRegRead) rdQ.push_back(oRegAddr);
    if (oRegWrite && oRegRead) bothCnt++;
    if ((oRegWrite && prevWr) || (oRegRead && prevRd)) longCnt++;
    prevWr = oRegWrite;
    prevRd = oRegRead;
    if (!oBusInterrupt) intLowCnt++;
    if (oBusMISOEnable) enHighCnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // One bus byte: falling edge with new MOSI, then the rising edge where MISO is sampled.
  task automatic busByte(input logic [7:0] mo, input bit deselAtRise, output logic [7:0] mi);
    iBusClock = 1'b0;
    iBusMOSI  = mo;
    waitCyc(6);
    mi = oBusMISO;
    iBusClock = 1'b1;
    if (deselAtRise) iBusSelect = 2'd0;
    waitCyc(6);
  endtask

  task automatic writeFrame(input logic [6:0] a);
    logic [7:0]  mi;
    logic [7:0]  dataOr;
    logic [31:0] w;
    logic [6:0]  wa;
    logic [38:0] expW [$];
    wrQ.delete();
    rdQ.delete();
    dataOr = 8'h00;
    iBusSelect = 2'd1;
    waitCyc(6);
    busByte({1'b1, a}, 1'b0, mi);
    check("wr_cmd_miso", 64'(mi), 64'({refPending, 6'd0, 1'b1}));
    foreach (wordsQ[k]) begin
      w = wordsQ[k];
      for (int b = 0; b < 4; b++) begin
        busByte(w[31:24], 1'b0, mi);
        dataOr = dataOr | mi;
        w = w << 8;
      end
    end
    waitCyc(2);
    iBusSelect = 2'd0;
    waitCyc(8);
    wa = a;
    foreach (wordsQ[k]) begin
      if (wa == 7'h7F) begin
        if (wordsQ[k][31]) refPending = 1'b0;
      end else begin
        expW.push_back({wa, wordsQ[k]});
        refMem[wa] = wordsQ[k];
      end
      wa = wa + 7'd1;
    end
    if (iIrqPulse) refPending = 1'b1;
    check("wr_data_miso", 64'(dataOr), 64'd0);
    check("wr_count", 64'(wrQ.size()), 64'(expW.size()));
    foreach (expW[k]) check("wr_strobe", (k < wrQ.size()) ? 64'(wrQ[k]) : 64'hDEAD, 64'(expW[k]));
    check("wr_no_read", 64'(rdQ.size()), 64'd0);
    check("wr_irq", 64'(oBusInterrupt), 64'(refPending));
  endtask

  // The last rise coincides with deselect, so no prefetch follows the final word.
  task automatic readFrame(input logic [6:0] a, input int n);
    logic [7:0]  mi;
    logic [31:0] got;
    logic [31:0] exp;
    logic [6:0]  ra;
    logic [6:0]  expR [$];
    wrQ.delete();
    rdQ.delete();
    iBusSelect = 2'd1;
    waitCyc(6);
    busByte({1'b0, a}, 1'b0, mi);
    check("rd_cmd_miso", 64'(mi), 64'({refPending, 6'd0, 1'b1}));
    ra = a;
    for (int k = 0; k < n; k++) begin
      got = 32'd0;
      for (int b = 0; b < 4; b++) begin
        busByte(8'h00, (k == n - 1) && (b == 3), mi);
        got = {got[23:0], mi};
      end
      exp = (ra == 7'h7F) ? {refPending, 31'd0} : refMem[ra];
      if (ra != 7'h7F) expR.push_back(ra);
      check("rd_word", 64'(got), 64'(exp));
      ra = ra + 7'd1;
    end
    waitCyc(8);
    check("rd_count", 64'(rdQ.size()), 64'(expR.size()));
    foreach (expR[k]) check("rd_addr", (k < rdQ.size()) ? 64'(rdQ[k]) : 64'hDEAD, 64'(expR[k]));
    check("rd_no_write", 64'(wrQ.size()), 64'd0);
    check("rd_miso_en_off", 64'(oBusMISOEnable), 64'd0);
  endtask

  initial begin
    logic [7:0] mi;
    logic [6:0] ra;
    int         n;

    iRst = 1'b1;
    iBusClock = 1'b1;
    iBusSelect = 2'd0;
    iBusMOSI = 8'h00;
    iIrqPulse = 1'b0;
    refPending = 1'b0;
    for (int i = 0; i < 128; i++) begin
      devMem[i] = $urandom;
      refMem[i] = devMem[i];
    end
    waitCyc(4);
    check("reset_outputs", 64'({oBusMISO, oBusMISOEnable, oBusInterrupt, oRegAddr, oRegWData, oRegWrite, oRegRead}), 64'd0);
    iRst = 1'b0;
    waitCyc(6);

    // Single write: command 8'h85 then DEADBEEF.
    wordsQ = '{32'hDEADBEEF};
    writeFrame(7'h05);
    check("single_wr_mem", 64'(devMem[5]), 64'h00000000DEADBEEF);

    // Burst read of two words with prefetch.
    devMem[7'h10] = 32'h11223344; refMem[7'h10] = 32'h11223344;
    devMem[7'h11] = 32'h55667788; refMem[7'h11] = 32'h55667788;
    readFrame(7'h10, 2);

    // Interrupt raise and status read.
    check("irq_idle", 64'(oBusInterrupt), 64'd0);
    iIrqPulse = 1'b1;
    waitCyc(1);
    iIrqPulse = 1'b0;
    waitCyc(1);
    check("irq_raise_2cyc", 64'(oBusInterrupt), 64'd1);
    refPending = 1'b1;
    readFrame(7'h7F, 1);

    // Wrap through the status register: 7E written, 7F clears pending, then 00.
    wordsQ = '{32'hCAFEF00D, 32'h80000000, 32'h0BADBEEF};
    writeFrame(7'h7E);

    // Set wins over a simultaneous clear.
    iIrqPulse = 1'b1;
    waitCyc(3);
    refPending = 1'b1;
    intLowCnt = 0;
    wordsQ = '{32'h80000000};
    writeFrame(7'h7F);
    check("irq_set_wins", 64'(intLowCnt), 64'd0);
    iIrqPulse = 1'b0;
    waitCyc(2);
    writeFrame(7'h7F);

    // Abort after two data bytes.
    wrQ.delete();
    iBusSelect = 2'd1;
    waitCyc(6);
    busByte(8'h85, 1'b0, mi);
    busByte(8'h12, 1'b0, mi);
    busByte(8'h34, 1'b0, mi);
    iBusSelect = 2'd0;
    waitCyc(8);
    check("abort_no_write", 64'(wrQ.size()), 64'd0);
    check("abort_miso_en", 64'(oBusMISOEnable), 64'd0);
    wordsQ = '{32'h600DCAFE};
    writeFrame(7'h06);
    readFrame(7'h06, 1);

    // Another device's select code.
    enHighCnt = 0;
    wrQ.delete();
    iBusSelect = 2'd2;
    waitCyc(6);
    busByte(8'h85, 1'b0, mi);
    for (int b = 0; b < 4; b++) busByte(8'hA5, 1'b0, mi);
    iBusSelect = 2'd0;
    waitCyc(8);
    check("other_sel_en", 64'(enHighCnt), 64'd0);
    check("other_sel_wr", 64'(wrQ.size()), 64'd0);

    // Reset in the middle of a read frame.
    wrQ.delete();
    iBusSelect = 2'd1;
    waitCyc(6);
    busByte(8'h05, 1'b0, mi);
    busByte(8'h00, 1'b0, mi);
    busByte(8'h00, 1'b0, mi);
    iRst = 1'b1;
    waitCyc(1);
    check("midreset_outputs", 64'({oBusMISO, oBusMISOEnable, oBusInterrupt, oRegAddr, oRegWData, oRegWrite, oRegRead}), 64'd0);
    iBusSelect = 2'd0;
    waitCyc(2);
    iRst = 1'b0;
    waitCyc(8);
    check("midreset_no_write", 64'(wrQ.size()), 64'd0);
    readFrame(7'h05, 1);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      ra = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        wordsQ.delete();
        for (int k = 0; k < n; k++) wordsQ.push_back($urandom);
        writeFrame(ra);
      end else begin
        readFrame(ra, n);
      end
    end

    check("strobe_exclusive", 64'(bothCnt), 64'd0);
    check("strobe_single_cycle", 64'(longCnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
